// File: rtl/mem_port_arbiter.sv
// Serializes instruction-fetch and load/store requests onto the single memory port.
// Each access takes three cycles: accept (IDLE), drive the memory (ACCESS), report completion (DONE).
module mem_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              f_done,
    output logic              d_done,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    state_t              state_reg, state_next;
    logic                owner_reg, owner_next;
    logic                last_owner_reg, last_owner_next;
    logic                we_reg, we_next;
    logic                oor_reg, oor_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                grant_data;
    logic [ADDR_W-1:0]   sel_addr;
    logic [1:0]          done_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            owner_reg      <= OWNER_FETCH;
            last_owner_reg <= OWNER_DATA;
            we_reg         <= 1'b0;
            oor_reg        <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            we_reg         <= we_next;
            oor_reg        <= oor_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
        end
    end

    // On a tie, data wins only if fetch was the last one served.
    assign grant_data = d_req && (!f_req || (last_owner_reg == OWNER_FETCH));
    assign sel_addr   = grant_data ? d_addr : f_addr;

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        we_next         = we_reg;
        oor_next        = oor_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (f_req || d_req) begin
                    owner_next      = grant_data ? OWNER_DATA : OWNER_FETCH;
                    last_owner_next = grant_data ? OWNER_DATA : OWNER_FETCH;
                    addr_next       = sel_addr;
                    we_next         = grant_data && d_we;
                    wdata_next      = grant_data ? d_wdata : '0;
                    oor_next        = ({1'b0, sel_addr} >= DEPTH_LIM);
                    state_next      = ACCESS;
                end
            end
            ACCESS: begin
                rdata_next = oor_reg ? '0 : mem_rdata;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Port outputs decode straight from state so an async reset drops mem_write at once.
    assign busy      = (state_reg != IDLE);
    assign mem_addr  = busy ? addr_reg : '0;
    assign mem_wdata = busy ? wdata_reg : '0;
    assign mem_write = (state_reg == ACCESS) && we_reg && !oor_reg;
    assign err       = (state_reg == DONE) && oor_reg;
    assign rdata     = rdata_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_done
            assign done_vec[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign f_done = done_vec[0];
    assign d_done = done_vec[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed fetch and reset-abort cases, then randomized
// contention against a transaction-level model with a shadow copy of memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [5:0]  f_addr;
    logic        d_req;
    logic        d_we;
    logic [5:0]  d_addr;
    logic [31:0] d_wdata;
    logic [31:0] rdata;
    logic        f_done;
    logic        d_done;
    logic        err;
    logic        busy;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [0:31];
    logic [31:0] ref_mem [0:31];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(6), .DATA_W(32), .DEPTH(32)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .rdata(rdata), .f_done(f_done), .d_done(d_done), .err(err), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'h0c000005;
        return 32'ha5000000 ^ (32'(i) * 32'h01010101);
    endfunction

    // 32-word memory, wraps on the low five address bits.
    assign mem_rdata = mem[mem_addr[4:0]];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_addr[4:0]] = mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    int          age;
    logic        last_data;
    logic        m_data, m_we, m_oor, done_f, done_d, hold;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
        reset = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_f_done", f_done, 0);
        check("rst_d_done", d_done, 0);
        check("rst_err", err, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single fetch of word 1.
        @(negedge clk);
        f_req = 1'b1; f_addr = 6'd1;
        @(negedge clk);
        check("fetch_acc_busy", busy, 1);
        check("fetch_acc_addr", mem_addr, 1);
        check("fetch_acc_we", mem_write, 0);
        check("fetch_acc_done", f_done, 0);
        @(negedge clk);
        check("fetch_done", f_done, 1);
        check("fetch_d_done", d_done, 0);
        check("fetch_rdata", rdata, 32'h0c000005);
        check("fetch_err", err, 0);
        check("fetch_done_we", mem_write, 0);
        f_req = 1'b0;
        @(negedge clk);
        check("fetch_after_done", f_done, 0);
        check("fetch_after_busy", busy, 0);

        // Store to word 3 aborted by reset during ACCESS.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd3; d_wdata = 32'h12345678;
        @(posedge clk);
        #2;
        check("abort_we_before", mem_write, 1);
        reset = 1'b1;
        #1;
        check("abort_we_after", mem_write, 0);
        check("abort_busy", busy, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_mem_wdata", mem_wdata, 0);
        check("abort_rdata", rdata, 0);
        check("abort_done", {f_done, d_done, err}, 0);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", {f_done, d_done, busy}, 0);
        end
        check("abort_word3", mem[3], init_word(3));

        // Randomized traffic; age = edges since the model's last acceptance.
        age = -1;
        last_data = 1'b1;
        m_data = 1'b0; m_we = 1'b0; m_oor = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (age < 0 || age >= 2) begin
                if (f_req || d_req) begin
                    m_data    = d_req && (!f_req || !last_data);
                    last_data = m_data;
                    m_addr    = m_data ? d_addr : f_addr;
                    m_we      = m_data && d_we;
                    m_wdata   = d_wdata;
                    m_oor     = (m_addr >= 6'd32);
                    m_rdata   = m_oor ? 32'h0 : ref_mem[m_addr[4:0]];
                    if (m_we && !m_oor) ref_mem[m_addr[4:0]] = m_wdata;
                    age = 0;
                end else begin
                    age = -1;
                end
            end else begin
                age++;
            end

            check("busy", busy, (age == 0 || age == 1) ? 1 : 0);
            check("mem_write", mem_write, (age == 0 && m_we && !m_oor) ? 1 : 0);
            check("mem_addr", mem_addr, (age == 0 || age == 1) ? 32'(m_addr) : 0);
            if ((age == 0 || age == 1) && m_we) check("mem_wdata", mem_wdata, m_wdata);
            done_f = (age == 1) && !m_data;
            done_d = (age == 1) && m_data;
            check("f_done", f_done, done_f);
            check("d_done", d_done, done_d);
            if (age == 1) begin
                check("err", err, m_oor);
                if (!m_we) check("rdata", rdata, m_rdata);
            end else begin
                check("err_idle", err, 0);
            end

            hold = done_f && ($urandom_range(0, 3) == 0);
            if ((!f_req || done_f) && !hold) begin
                if ($urandom_range(0, 2) != 0) begin
                    f_req = 1'b1; f_addr = 6'($urandom_range(0, 39));
                end else begin
                    f_req = 1'b0;
                end
            end
            hold = done_d && ($urandom_range(0, 3) == 0);
            if ((!d_req || done_d) && !hold) begin
                if ($urandom_range(0, 2) != 0) begin
                    d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                    d_addr = 6'($urandom_range(0, 47)); d_wdata = $urandom;
                end else begin
                    d_req = 1'b0;
                end
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 32; i++) check("mem_final", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the unified single-port instruction/data memory of the multi-cycle CPU. It accepts read requests from the instruction-fetch path and read/write requests from the load/store path, and serializes them onto the one memory port. It owns the memory's address, write-data and write-enable lines, and returns read data with a one-cycle done pulse per requester. It sits between the CPU control unit and the memory: memory read is combinational, memory write is on the rising clock edge.

## Interface
- ADDR_W, 6, word-address width (matches memory address port)
- DATA_W, 32, data width
- DEPTH, 32, implemented words; addresses >= DEPTH are out of range
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- f_req  in  1  fetch request; held high until f_done is sampled
- f_addr  in  ADDR_W  fetch word address; stable while f_req high
- d_req  in  1  data request; held high until d_done is sampled
- d_we  in  1  1 = store, 0 = load; stable while d_req high
- d_addr  in  ADDR_W  data word address; stable while d_req high
- d_wdata  in  DATA_W  store data; stable while d_req high
- rdata  out  DATA_W  read data, valid in the cycle f_done or d_done is high
- f_done  out  1  one-cycle completion pulse for fetch
- d_done  out  1  one-cycle completion pulse for data access
- err  out  1  out-of-range flag, valid with f_done/d_done
- busy  out  1  high in ACCESS and DONE
- mem_addr  out  ADDR_W  to memory address port
- mem_wdata  out  DATA_W  to memory write-data port
- mem_write  out  1  to memory write enable
- mem_rdata  in  DATA_W  from memory combinational read port

## Operation
- States: IDLE, ACCESS, DONE. Reset state IDLE.
- IDLE: if no request, stay. Else choose winner, latch owner, addr, we (0 for fetch), wdata, range flag (addr >= DEPTH); go ACCESS.
- Arbitration: only one pending -> it wins. Both pending -> the requester not served last wins (last_owner register, reset value DATA, so first tie goes to fetch). last_owner updates on each IDLE->ACCESS transition.
- ACCESS: mem_addr = latched addr; mem_wdata = latched wdata; mem_write = latched we AND in-range. Capture rdata <= in-range ? mem_rdata : 0 (for stores rdata captured but meaningless). Go DONE.
- DONE: pulse done of latched owner; err = latched range flag; go IDLE unconditionally.
- Out-of-range: no memory write, rdata = 0, err = 1 with done.
- Requesters may not change request fields while req high; a request left high after its done is sampled is treated as a new request.
- Losing requester keeps req high and is served next access; no request is dropped.

## Timing
- Reset values: rdata 0, f_done 0, d_done 0, err 0, busy 0, mem_addr 0, mem_wdata 0, mem_write 0, last_owner DATA, state IDLE.
- Reset asserted mid-ACCESS: mem_write drops asynchronously; no write on that edge; pending access abandoned, no done issued.
- mem_addr/mem_wdata hold latched values in ACCESS and DONE; driven 0 in IDLE.
- mem_write is high only during ACCESS; the memory write occurs on the edge ending ACCESS.
- Latency: req sampled high at edge k (state IDLE) -> ACCESS in cycle k..k+1 -> done high in cycle after edge k+1. Done visible 2 cycles after sampling edge.
- Throughput: one access per 3 cycles; back-to-back requests: next acceptance at the IDLE cycle following DONE.
- f_done and d_done never high in the same cycle.

## Test plan
- Single fetch: memory word 1 = 32'h0c000005, f_req with f_addr=1 -> f_done one cycle, 2 cycles after sampling edge, rdata=32'h0c000005, err=0, mem_write never high.
- Store then load: d_req, d_we=1, d_addr=20, d_wdata=32'hdeadbeef -> mem_write high exactly one cycle with mem_addr=20, d_done; then load addr 20 -> rdata=32'hdeadbeef.
- Contention: f_req and d_req raised same cycle and held -> fetch served first (f_done), data next (d_done 3 cycles later); repeat with both held -> strict alternation, no starvation.
- Out of range: d_req store to addr 40 -> d_done with err=1, mem_write stays 0, word 40 mod 32 (=8) unchanged; load from 40 -> rdata=0, err=1.
- Reset mid-access: assert reset during ACCESS of a store to addr 3 -> mem_write falls immediately, word 3 unchanged, no done, all outputs at reset values, next fetch after release completes normally.
- Held request: d_req left high after d_done -> second identical access issued, second d_done exactly 3 cycles after first.
